alarm_ring_arbiter: RTL and testbench
=====================================

// Module: alarm_ring_arbiter
// PURPOSE
//  Shares the single buzzer and alarm screen among ALARMS_CNT alarm_clock instances.
//  Grants one ringing alarm at a time and routes the user off/snooze strobes only to the granted alarm.
//  Drives the buzzer beep pattern and the vga_mux select (time screen vs alarm screen).
//  Sits in the alarm clock top level, between the alarm_clock alarm_o outputs and alarm_ctrl_if/vga_mux.
// PARAMETERS
//  ALARMS_CNT       7           number of alarm requesters, 1..16
//  BEEP_HALF_CYCLES 12_500_000  buzzer on/off half-period in clk_i cycles (0.25 s at 50 MHz), >=1
//  GUARD_CYCLES     1024        dead time after a ring ends before re-arbitration, >=1
//  TIME_MODE        1           show_mode_o value while not ringing
//  ALARM_MODE       2           show_mode_o value while ringing
// PORTS
//  clk_i            in   1              system clock (50 MHz)
//  rst_i            in   1              asynchronous reset, active-high
//  alarm_i          in   ALARMS_CNT     ring requests, level, from alarm_clock alarm_o
//  off_stb_i        in   1              user "alarm off" pulse, 1 cycle
//  snooze_stb_i     in   1              user "snooze" pulse, 1 cycle
//  alarm_off_stb_o  out  ALARMS_CNT     per-alarm off strobe, one-hot, 1 cycle
//  alarm_snz_stb_o  out  ALARMS_CNT     per-alarm snooze strobe, one-hot, 1 cycle
//  active_idx_o     out  $clog2(ALARMS_CNT) (min 1)  index of granted alarm
//  active_vld_o     out  1              high while in RING
//  buzzer_o         out  1              beep output
//  show_mode_o      out  2              vga_mux mode select
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, strobes 0, active_idx_o 0, active_vld_o 0,
//    buzzer_o 0, show_mode_o TIME_MODE, beep counter 0, guard counter 0, RR pointer 0.
//  - States: IDLE, RING, GUARD.
//  - IDLE: if |alarm_i, latch winner into active_idx_o, go RING next cycle; active_vld_o=1,
//    buzzer_o=1, show_mode_o=ALARM_MODE, beep counter cleared, all in that same edge.
//    Winner selection (default): fixed priority, lowest set index.
//  - RING: beep counter counts 0..BEEP_HALF_CYCLES-1; at terminal count wraps to 0 and toggles buzzer_o.
//    Grant is held; new/other requests do not pre-empt.
//  - RING exits (checked in order, first match wins, exit takes effect next edge):
//    1) off_stb_i=1          -> alarm_off_stb_o[idx]=1 for exactly 1 cycle, go GUARD
//    2) snooze_stb_i=1       -> alarm_snz_stb_o[idx]=1 for exactly 1 cycle, go GUARD
//    3) alarm_i[idx]=0       -> no strobe (alarm self-timed out), go GUARD
//    Off and snooze in the same cycle: off wins, snooze discarded.
//    On exit: active_vld_o=0, buzzer_o=0, show_mode_o=TIME_MODE; active_idx_o keeps last value.
//  - GUARD: counts GUARD_CYCLES cycles, then IDLE. Strobes ignored; requests ignored (not latched).
//  - off_stb_i/snooze_stb_i outside RING: dropped, no output strobe ever.
//  - Strobe latency: 1 cycle from input pulse to output pulse. Strobe outputs never multi-hot.
//  - Reset asserted mid-RING: buzzer and strobes go 0 immediately (async); no strobe emitted.
//  - Simultaneous requests: exactly one granted; others re-arbitrated after GUARD if still high.
// CONFIGURATION
//  ALARM_ARB_ROUND_ROBIN_EN defined: winner = first set bit at or above RR pointer, wrapping
//    modulo ALARMS_CNT; on grant, pointer <= (granted index + 1) mod ALARMS_CNT.
//  Not defined: fixed lowest-index priority; no RR pointer logic is built.
// TESTING  (use BEEP_HALF_CYCLES=4, GUARD_CYCLES=8, ALARMS_CNT=7)
//  - Reset then alarm_i=7'b0000100 -> next cycle active_vld_o=1, active_idx_o=2, show_mode_o=2;
//    buzzer_o 1,1,1,1,0,0,0,0,1... period 8 cycles.
//  - RING idx 2, pulse off_stb_i -> alarm_off_stb_o=7'b0000100 for 1 cycle only, buzzer_o=0,
//    show_mode_o=1; GUARD 8 cycles with off_stb_i pulses -> no strobes; then IDLE.
//  - off_stb_i and snooze_stb_i same cycle in RING -> only alarm_off_stb_o pulses; snooze outputs stay 0.
//  - alarm_i=7'b1000001 -> idx 0 granted; off; after GUARD idx 6 granted (bit 6 still high).
//    With ALARM_ARB_ROUND_ROBIN_EN: alarm_i=7'b0000011 constant -> grants 0,1,0,1 on successive rings.
//  - RING idx 3, drop alarm_i[3] -> GUARD, no strobe; snooze_stb_i in IDLE -> no strobe.
//  - Assert rst_i mid-RING while buzzer_o=1 -> buzzer_o=0 and active_vld_o=0 before next clk edge.

Source files
------------

// File: rtl/alarm_ring_arbiter_if.sv
// Handshake bundle between the alarm_clock requesters / user strobes and the ring arbiter.
// The slave modport is the arbiter side; the master modport is the requester/user side.
interface alarm_ring_arbiter_if #(
  parameter int unsigned ALARMS_CNT = 7
);
  localparam int unsigned IdxW = (ALARMS_CNT > 1) ? $clog2(ALARMS_CNT) : 1;

  logic [ALARMS_CNT-1:0] alarm_i;
  logic                  off_stb_i;
  logic                  snooze_stb_i;
  logic [ALARMS_CNT-1:0] alarm_off_stb_o;
  logic [ALARMS_CNT-1:0] alarm_snz_stb_o;
  logic [IdxW-1:0]       active_idx_o;
  logic                  active_vld_o;
  logic                  buzzer_o;
  logic [1:0]            show_mode_o;

  modport master (
    output alarm_i, off_stb_i, snooze_stb_i,
    input  alarm_off_stb_o, alarm_snz_stb_o, active_idx_o, active_vld_o, buzzer_o, show_mode_o
  );

  modport slave (
    input  alarm_i, off_stb_i, snooze_stb_i,
    output alarm_off_stb_o, alarm_snz_stb_o, active_idx_o, active_vld_o, buzzer_o, show_mode_o
  );
endinterface

// File: rtl/alarm_ring_arbiter.sv
// Grants one ringing alarm at a time, drives the buzzer beep and the vga_mux screen select.
// Define ALARM_ARB_ROUND_ROBIN_EN for round-robin winner selection (default: lowest index wins).
module alarm_ring_arbiter #(
  parameter int unsigned ALARMS_CNT       = 7,
  parameter int unsigned BEEP_HALF_CYCLES = 12_500_000,
  parameter int unsigned GUARD_CYCLES     = 1024,
  parameter int unsigned TIME_MODE        = 1,
  parameter int unsigned ALARM_MODE       = 2
) (
  input logic                 clk_i,
  input logic                 rst_i,
  alarm_ring_arbiter_if.slave bus
);

  localparam int unsigned IdxW   = (ALARMS_CNT > 1) ? $clog2(ALARMS_CNT) : 1;
  localparam int unsigned BeepW  = (BEEP_HALF_CYCLES > 1) ? $clog2(BEEP_HALF_CYCLES) : 1;
  localparam int unsigned GuardW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StRing, StGuard} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  vld_q, vld_d;
  logic                  buz_q, buz_d;
  logic [1:0]            mode_q, mode_d;
  logic [BeepW-1:0]      beep_q, beep_d;
  logic [GuardW-1:0]     guard_q, guard_d;
  logic [ALARMS_CNT-1:0] off_q, off_d;
  logic [ALARMS_CNT-1:0] snz_q, snz_d;
  logic [IdxW-1:0]       win_idx;

`ifdef ALARM_ARB_ROUND_ROBIN_EN
  logic [IdxW-1:0] rr_q, rr_d;

  // Descending scan so the set bit closest above the pointer is the last (winning) assignment.
  always_comb begin
    int unsigned j;
    j       = 0;
    win_idx = '0;
    for (int k = int'(ALARMS_CNT) - 1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= ALARMS_CNT) j = j - ALARMS_CNT;
      if (bus.alarm_i[j]) win_idx = IdxW'(j);
    end
  end
`else
  always_comb begin
    win_idx = '0;
    for (int k = int'(ALARMS_CNT) - 1; k >= 0; k--) begin
      if (bus.alarm_i[k]) win_idx = IdxW'(k);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    buz_d   = buz_q;
    mode_d  = mode_q;
    beep_d  = beep_q;
    guard_d = guard_q;
    off_d   = '0;
    snz_d   = '0;
`ifdef ALARM_ARB_ROUND_ROBIN_EN
    rr_d    = rr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|bus.alarm_i) begin
          state_d = StRing;
          idx_d   = win_idx;
          vld_d   = 1'b1;
          buz_d   = 1'b1;
          mode_d  = 2'(ALARM_MODE);
          beep_d  = '0;
`ifdef ALARM_ARB_ROUND_ROBIN_EN
          rr_d    = (int'(win_idx) == int'(ALARMS_CNT) - 1) ? '0 : win_idx + IdxW'(1);
`endif
        end
      end
      StRing: begin
        if (bus.off_stb_i || bus.snooze_stb_i || !bus.alarm_i[idx_q]) begin
          // Off outranks snooze; a self-timed-out alarm leaves without any strobe.
          if (bus.off_stb_i) off_d[idx_q] = 1'b1;
          else if (bus.snooze_stb_i) snz_d[idx_q] = 1'b1;
          state_d = StGuard;
          vld_d   = 1'b0;
          buz_d   = 1'b0;
          mode_d  = 2'(TIME_MODE);
          guard_d = '0;
        end else if (beep_q == BeepW'(BEEP_HALF_CYCLES - 1)) begin
          beep_d = '0;
          buz_d  = ~buz_q;
        end else begin
          beep_d = beep_q + BeepW'(1);
        end
      end
      StGuard: begin
        if (guard_q == GuardW'(GUARD_CYCLES - 1)) begin
          state_d = StIdle;
          guard_d = '0;
        end else begin
          guard_d = guard_q + GuardW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      buz_q   <= 1'b0;
      mode_q  <= 2'(TIME_MODE);
      beep_q  <= '0;
      guard_q <= '0;
      off_q   <= '0;
      snz_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      buz_q   <= buz_d;
      mode_q  <= mode_d;
      beep_q  <= beep_d;
      guard_q <= guard_d;
      off_q   <= off_d;
      snz_q   <= snz_d;
    end
  end

`ifdef ALARM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end
`endif

  assign bus.alarm_off_stb_o = off_q;
  assign bus.alarm_snz_stb_o = snz_q;
  assign bus.active_idx_o    = idx_q;
  assign bus.active_vld_o    = vld_q;
  assign bus.buzzer_o        = buz_q;
  assign bus.show_mode_o     = mode_q;

endmodule

// File: tb/tb_alarm_ring_arbiter.sv
// Randomized bench for alarm_ring_arbiter against a timeline-style reference model.
module tb_alarm_ring_arbiter;

  localparam int unsigned N     = 7;
  localparam int unsigned BEEP  = 4;
  localparam int unsigned GUARD = 8;

  logic clk;
  logic rst;

  alarm_ring_arbiter_if #(.ALARMS_CNT(N)) bus ();

  alarm_ring_arbiter #(
    .ALARMS_CNT      (N),
    .BEEP_HALF_CYCLES(BEEP),
    .GUARD_CYCLES    (GUARD),
    .TIME_MODE       (1),
    .ALARM_MODE      (2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a ring is described by its grant index and age in cycles,
  // the guard by the number of dead cycles still to run.
  bit       m_ringing;
  int       m_idx;
  int       m_age;
  int       m_guard_left;
  bit [N-1:0] m_off;
  bit [N-1:0] m_snz;
  int       m_rr;

  function automatic int pick_winner(input logic [N-1:0] a, input int start);
    for (int k = 0; k < int'(N); k++) begin
      if (a[(start + k) % N]) return (start + k) % N;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_ringing    = 0;
    m_idx        = 0;
    m_age        = 0;
    m_guard_left = 0;
    m_off        = '0;
    m_snz        = '0;
    m_rr         = 0;
  endtask

  task automatic model_step(input logic [N-1:0] a, input logic off, input logic snz);
    m_off = '0;
    m_snz = '0;
    if (m_ringing) begin
      if (off || snz || !a[m_idx]) begin
        if (off) m_off = N'(1) << m_idx;
        else if (snz) m_snz = N'(1) << m_idx;
        m_ringing    = 0;
        m_guard_left = GUARD;
      end else begin
        m_age++;
      end
    end else if (m_guard_left > 0) begin
      m_guard_left--;
    end else if (a != '0) begin
`ifdef ALARM_ARB_ROUND_ROBIN_EN
      m_idx = pick_winner(a, m_rr);
      m_rr  = (m_idx + 1) % N;
`else
      m_idx = pick_winner(a, 0);
`endif
      m_ringing = 1;
      m_age     = 0;
    end
  endtask

  function automatic bit exp_buzzer();
    return m_ringing && (((m_age / BEEP) % 2) == 0);
  endfunction

  task automatic check_outputs();
    check("active_vld", 32'(bus.active_vld_o), 32'(m_ringing));
    check("active_idx", 32'(bus.active_idx_o), 32'(m_idx));
    check("buzzer", 32'(bus.buzzer_o), 32'(exp_buzzer()));
    check("show_mode", 32'(bus.show_mode_o), m_ringing ? 32'd2 : 32'd1);
    check("off_stb", 32'(bus.alarm_off_stb_o), 32'(m_off));
    check("snz_stb", 32'(bus.alarm_snz_stb_o), 32'(m_snz));
  endtask

  // Called at a negedge: drive inputs, let the edge happen, then compare.
  task automatic run_cycle(input logic [N-1:0] a, input logic off, input logic snz);
    bus.alarm_i      = a;
    bus.off_stb_i    = off;
    bus.snooze_stb_i = snz;
    @(posedge clk);
    model_step(a, off, snz);
    @(negedge clk);
    check_outputs();
  endtask

  logic [N-1:0] a;
  logic         off;
  logic         snz;
  int           resets_done;

  initial begin
    rst              = 1'b1;
    bus.alarm_i      = '0;
    bus.off_stb_i    = 1'b0;
    bus.snooze_stb_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Directed opening: single request, full beep period, off in RING, strobes during GUARD.
    for (int i = 0; i < 12; i++) run_cycle(7'b0000100, 1'b0, 1'b0);
    run_cycle(7'b0000100, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) run_cycle(7'b0000100, (i % 2) == 0, (i % 3) == 0);
    run_cycle(7'b1000001, 1'b0, 1'b0);
    run_cycle(7'b1000001, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) run_cycle(7'b1000001, 1'b0, 1'b0);
    run_cycle(7'b0001000, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) run_cycle(7'b0000000, 1'b0, i == 3);

    // Random phase with occasional async resets while the buzzer is on.
    a           = N'($urandom);
    resets_done = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) a[$urandom_range(0, N - 1)] ^= 1'b1;
      off = ($urandom_range(0, 24) == 0);
      snz = ($urandom_range(0, 24) == 0) || (off && $urandom_range(0, 1) == 1);
      run_cycle(a, off, snz);
      if (i > 500 * (resets_done + 1) && resets_done < 3 && exp_buzzer()) begin
        rst = 1'b1;
        #1;
        check("rst_buzzer", 32'(bus.buzzer_o), 32'd0);
        check("rst_vld", 32'(bus.active_vld_o), 32'd0);
        check("rst_off_stb", 32'(bus.alarm_off_stb_o), 32'd0);
        check("rst_snz_stb", 32'(bus.alarm_snz_stb_o), 32'd0);
        check("rst_mode", 32'(bus.show_mode_o), 32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        resets_done++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
